uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter (`uart_tx` inside `UART_top`) between several byte producers, e.g. the RX echo path, a status reporter and a debug dump. Each requester offers bytes on a valid/ready interface. The arbiter picks one requester, hands its byte to the transmitter as a one-cycle start pulse, waits for the frame to finish, then re-arbitrates. It sits between the producers and `uart_tx`, in the `UART_top` clock domain.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; legal range 2..8.
- `DATA_W`, 8: byte width; must match the transmitter.
- `ACK_TIMEOUT`, 8: cycles allowed for `tx_busy` to rise after `tx_start`.

Ports:
- `clk` in 1: system clock (50 MHz).
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in N_REQ: per-requester byte valid.
- `req_data` in N_REQ*DATA_W: requester i's byte at `[i*DATA_W +: DATA_W]`.
- `req_last` in N_REQ: last byte of a packet; used only with the lock feature.
- `req_ready` out N_REQ: one-hot grant-accept; a byte is consumed when `valid & ready`.
- `tx_start` out 1: one-cycle pulse to the transmitter.
- `tx_data` out DATA_W: byte for the transmitter, stable from `tx_start` until `tx_busy` falls.
- `tx_busy` in 1: transmitter frame in progress.
- `grant_id` out $clog2(N_REQ): index of the current or last granted requester.
- `arb_busy` out 1: high in every state except IDLE.
- `ack_err` out 1: one-cycle pulse when the `tx_busy` timeout expires.

## Operation
- FSM states:
  - IDLE: if any `req_valid`, choose winner `w` → GRANT.
  - GRANT: `req_ready[w]`=1 for exactly 1 cycle; latch `req_data[w]` into `tx_data` and `req_last[w]` into the last flag → START.
  - START: `tx_start`=1 → WAIT_ACK.
  - WAIT_ACK: `tx_busy`=1 → WAIT_DONE; `ACK_TIMEOUT` cycles with `tx_busy`=0 → pulse `ack_err`, → IDLE.
  - WAIT_DONE: `tx_busy`=0 → IDLE.
- Round-robin: priority search starts at `(ptr+1) mod N_REQ`; `ptr` is updated to `w` on entering GRANT.
- Requesters must hold `req_valid` and data stable until accepted. A requester that drops `req_valid` before GRANT is not granted, and arbitration repeats from IDLE.
- At most one `req_ready` bit is high at any time. `req_ready` is high only in GRANT and is registered, with no combinational path from `req_valid`.
- The winner is sampled in the IDLE cycle. `req_valid` changes during GRANT do not change `w`.
- Reset mid-frame: all state clears immediately. The transmitter is reset by the same `rst_n`.

## Timing
- Reset values: `req_ready`=0, `tx_start`=0, `tx_data`=0, `grant_id`=0, `arb_busy`=0, `ack_err`=0, `ptr`=N_REQ-1 (so requester 0 wins first), FSM=IDLE.
- Byte turnaround: `req_valid` seen in IDLE at cycle t, `req_ready` at t+1, `tx_start` at t+2.
- Next arbitration is in the cycle after `tx_busy` falls, so there are 3 cycles of overhead per byte plus the frame time (10 bit periods of `CLK_FREQUENCE/BAUD_RATE` clocks each).
- The timeout counter clears on entering WAIT_ACK and counts cycles with `tx_busy`=0. `ack_err` fires on the cycle the count reaches `ACK_TIMEOUT`.

## Configuration
- `UART_ARB_PKT_LOCK_EN` defined:
  - After a granted byte whose `req_last`=0, IDLE considers only requester `ptr` (no rotation) until a byte with `req_last`=1 completes.
  - An `ack_err` releases the lock.
  - If the locked requester has no valid byte, the arbiter waits in IDLE.
- Not defined: `req_last` is ignored and re-arbitration happens after every byte.

## Structure
- Package `uart_arb_pkg`: FSM state enum (IDLE, GRANT, START, WAIT_ACK, WAIT_DONE), `N_REQ_MAX`=8, and the id-width localparam helper.
- Sub-module `uart_rr_picker`: combinational rotate-priority encoder. Inputs: `req_valid` and `ptr`. Outputs: `any` and `w`.

## Test plan
- Single byte: after reset, requester 2 offers 8'hEC → `req_ready[2]` 1 cycle later, `tx_start` 2 cycles later, `tx_data`=8'hEC, serial line shows 0,0,0,1,1,0,1,1,1,1.
- Fairness: all 4 requesters continuously valid, 8 bytes sent → grant order 0,1,2,3,0,1,2,3.
- Simultaneous arrival: requesters 1 and 3 valid in the same cycle with `ptr`=1 → 3 is served first, then 1.
- Timeout: stub `tx_busy` tied 0 → `ack_err` pulses `ACK_TIMEOUT` cycles after `tx_start`, FSM returns to IDLE, and the next request is still served.
- Lock (`UART_ARB_PKT_LOCK_EN`): requester 0 sends a 3-byte packet (last on byte 3) while requester 1 is valid → bytes 0,0,0 then 1. Without the macro → 0,1,0,…
- Reset mid-frame: assert `rst_n`=0 during WAIT_DONE → all outputs reach their reset values asynchronously. After release, requester 0 wins first.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmitter arbiter.
// The optional packet-lock feature is enabled by defining UART_ARB_PKT_LOCK_EN.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_START,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } arb_state_e;

  localparam int N_REQ_MAX = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational rotate-priority encoder: the first valid requester at or after
// (ptr+1) mod N_REQ wins, wrapping around so ptr itself is checked last.
module uart_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IW-1:0]    ptr,
  output logic             any,
  output logic [IW-1:0]    w
);

  logic [IW-1:0] idx;

  always_comb begin
    any = 1'b0;
    w   = '0;
    idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IW'((int'(ptr) + i) % N_REQ);
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        w   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Defining UART_ARB_PKT_LOCK_EN keeps the grant on one requester until req_last.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic [id_w(N_REQ)-1:0]  grant_id,
  output logic                    arb_busy,
  output logic                    ack_err
);

  localparam int IW = id_w(N_REQ);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  // Handshake: a requester holds req_valid and its data until it sees
  // valid & ready at a rising edge; req_ready is registered and one-hot,
  // high only during the single GRANT cycle of the chosen requester.

  arb_state_e        state, state_nxt;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     w;
  logic              any;
  logic [N_REQ-1:0]  cand_valid;
  logic [CW-1:0]     to_cnt;
  logic              accept;
  logic              timeout;
  logic [DATA_W-1:0] sel_data;

`ifdef UART_ARB_PKT_LOCK_EN
  logic pkt_lock;

  // While a packet is open only the owner (ptr) may win.
  assign cand_valid = pkt_lock ? (req_valid & (N_REQ'(1) << ptr)) : req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_lock <= 1'b0;
    end else if (timeout) begin
      pkt_lock <= 1'b0;
    end else if (accept) begin
      pkt_lock <= ~req_last[grant_id];
    end
  end
`else
  logic last_unused;

  assign cand_valid  = req_valid;
  assign last_unused = ^req_last;
`endif

  uart_rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req_valid (cand_valid),
    .ptr       (ptr),
    .any       (any),
    .w         (w)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == IW'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // A requester that dropped valid during GRANT is not consumed.
  assign accept  = (state == ST_GRANT) && req_valid[grant_id];
  assign timeout = (state == ST_WAIT_ACK) && !tx_busy &&
                   (to_cnt == CW'(ACK_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (any) state_nxt = ST_GRANT;
      ST_GRANT:     state_nxt = accept ? ST_START : ST_IDLE;
      ST_START:     state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (tx_busy)      state_nxt = ST_WAIT_DONE;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_WAIT_DONE: if (!tx_busy) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= IW'(N_REQ - 1);
      grant_id  <= '0;
      req_ready <= '0;
      tx_data   <= '0;
      to_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && any) begin
        ptr       <= w;
        grant_id  <= w;
        req_ready <= N_REQ'(1) << w;
      end else begin
        req_ready <= '0;
      end
      if (accept) tx_data <= sel_data;
      // Cleared in START so the count begins fresh on entering WAIT_ACK.
      if (state == ST_START) begin
        to_cnt <= '0;
      end else if (state == ST_WAIT_ACK && !tx_busy) begin
        to_cnt <= to_cnt + CW'(1);
      end
    end
  end

  assign tx_start = (state == ST_START);
  assign arb_busy = (state != ST_IDLE);
  assign ack_err  = timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter stub and
// a grant/data scoreboard; honours UART_ARB_PKT_LOCK_EN for the packet test.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int AT   = 8;
  localparam int BIT  = 4;
  localparam int SB_W = 2 + DW;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          arb_busy;
  logic          ack_err;

  logic          tx_line;
  logic          stub_dead;

  logic [8:0]      src_q[N][$];
  logic [SB_W-1:0] exp_q[$];

  int vectors = 0;
  int errors  = 0;

  uart_tx_arbiter #(
    .N_REQ       (N),
    .DATA_W      (DW),
    .ACK_TIMEOUT (AT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy),
    .ack_err   (ack_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // driver tasks
  task automatic send(input int id, input logic [7:0] d, input logic last);
    src_q[id].push_back({last, d});
  endtask

  task automatic expect_grant(input int id, input logic [7:0] d);
    exp_q.push_back({2'(id), d});
  endtask

  task automatic wait_drain(input string tag, input int limit);
    logic done;
    done = 1'b0;
    for (int n = 0; n < limit && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !arb_busy && !tx_busy &&
          src_q[0].size() == 0 && src_q[1].size() == 0 &&
          src_q[2].size() == 0 && src_q[3].size() == 0)
        done = 1'b1;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  // requester model: holds each queued byte until valid & ready is seen
  initial begin
    logic [N-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          req_valid[i]         = 1'b1;
          req_data[i*DW +: DW] = src_q[i][0][7:0];
          req_last[i]          = src_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // transmitter stub: 10-bit frame, BIT clocks per bit, busy from the cycle after tx_start
  initial begin
    tx_busy = 1'b0;
    tx_line = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && !stub_dead && rst_n) begin
        @(posedge clk);
        #1;
        tx_busy = 1'b1;
        for (int b = 0; b < 10 && rst_n; b++) begin
          tx_line = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : tx_data[b-1];
          repeat (BIT) @(posedge clk);
          #1;
        end
        tx_busy = 1'b0;
        tx_line = 1'b1;
      end
    end
  end

  // scoreboard: every tx_start must match the oldest expected grant
  initial begin
    logic [SB_W-1:0] e;
    forever begin
      @(negedge clk);
      if (req_ready != '0) check("ready_onehot", 32'($countones(req_ready)), 32'd1);
      if (tx_start === 1'b1) begin
        check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_grant", 32'({grant_id, tx_data}), 32'(e));
        end
      end
    end
  end

  initial begin
    int exp_bits[10] = '{0, 0, 0, 1, 1, 0, 1, 1, 1, 1};
    int n;
    logic [7:0] d;
    logic [7:0] d2;

    stub_dead = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);

    // reset values
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_data",  32'(tx_data), 32'd0);
    check("rst_gid",   32'(grant_id), 32'd0);
    check("rst_busy",  32'(arb_busy), 32'd0);
    check("rst_ackerr", 32'(ack_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single byte from requester 2, latency and serial frame
    send(2, 8'hEC, 1'b1);
    expect_grant(2, 8'hEC);
    n = 0;
    @(negedge clk);
    while (!req_valid[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("single_valid_seen", 32'(req_valid[2]), 32'd1);
    check("single_idle_t0", 32'(arb_busy), 32'd0);
    @(negedge clk);
    check("single_ready_t1", 32'(req_ready), 32'b0100);
    @(negedge clk);
    check("single_start_t2", 32'(tx_start), 32'd1);
    check("single_data_t2", 32'(tx_data), 32'hEC);
    for (int b = 0; b < 10; b++) begin
      repeat ((b == 0) ? 1 : BIT) @(negedge clk);
      check($sformatf("serial_bit%0d", b), 32'(tx_line), 32'(exp_bits[b]));
    end
    wait_drain("single_drain", 100);

    // fairness: all four requesters continuously valid
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        d = 8'($urandom_range(0, 255));
        send(i, d, 1'b1);
        expect_grant(i, d);
      end
    end
    wait_drain("fair_drain", 800);

    // simultaneous arrival with ptr = 1
    do_reset();
    d = 8'($urandom_range(0, 255));
    send(1, d, 1'b1);
    expect_grant(1, d);
    wait_drain("simul_setup_drain", 100);
    d  = 8'($urandom_range(0, 255));
    d2 = 8'($urandom_range(0, 255));
    send(3, d, 1'b1);
    send(1, d2, 1'b1);
    expect_grant(3, d);
    expect_grant(1, d2);
    wait_drain("simul_drain", 200);

    // acknowledge timeout with a dead transmitter
    stub_dead = 1'b1;
    send(0, 8'h3C, 1'b1);
    expect_grant(0, 8'h3C);
    n = 0;
    @(negedge clk);
    while (tx_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("to_start_seen", 32'(tx_start), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack_err !== 1'b1 && n < 40);
    check("to_latency", 32'(n), 32'(AT));
    @(negedge clk);
    check("to_pulse_width", 32'(ack_err), 32'd0);
    check("to_back_idle", 32'(arb_busy), 32'd0);
    stub_dead = 1'b0;
    send(2, 8'h96, 1'b1);
    expect_grant(2, 8'h96);
    wait_drain("to_recover_drain", 200);

    // packet lock: 3-byte packet on requester 0 while requester 1 waits
    do_reset();
    send(0, 8'h10, 1'b0);
    send(0, 8'h11, 1'b0);
    send(0, 8'h12, 1'b1);
    send(1, 8'h20, 1'b1);
`ifdef UART_ARB_PKT_LOCK_EN
    expect_grant(0, 8'h10);
    expect_grant(0, 8'h11);
    expect_grant(0, 8'h12);
    expect_grant(1, 8'h20);
`else
    expect_grant(0, 8'h10);
    expect_grant(1, 8'h20);
    expect_grant(0, 8'h11);
    expect_grant(0, 8'h12);
`endif
    wait_drain("lock_drain", 400);

    // reset mid-frame, then requester 0 must win first
    send(1, 8'hA5, 1'b1);
    expect_grant(1, 8'hA5);
    n = 0;
    @(negedge clk);
    while (tx_busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_busy_seen", 32'(tx_busy), 32'd1);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_start", 32'(tx_start), 32'd0);
    check("mid_rst_data",  32'(tx_data), 32'd0);
    check("mid_rst_gid",   32'(grant_id), 32'd0);
    check("mid_rst_busy",  32'(arb_busy), 32'd0);
    check("mid_rst_ackerr", 32'(ack_err), 32'd0);
    repeat (2 * BIT + 2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(3, 8'h33, 1'b1);
    send(0, 8'h44, 1'b1);
    expect_grant(0, 8'h44);
    expect_grant(3, 8'h33);
    wait_drain("mid_after_drain", 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
